alarm_status_encoder: RTL and testbench

- Central alarm-system state machine that produces the 3-bit colour command consumed by the RGB LED driver.
- Converts keypad results, arm requests and sensor trips into timed system states.
- Encodes each state onto color_out using the LED driver's colour code map.
- Sits between the keypad/sensor front-end and the RGB LED driver.

---
 rtl/alarm_status_encoder_if.sv | 34 +++
 rtl/alarm_status_encoder.sv | 228 ++++++++++++++++++++++
 tb/tb_alarm_status_encoder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_status_encoder_if.sv
// Groups the alarm encoder's event inputs and LED/status outputs.
// Latency: none (wires only).
// Backpressure: none; the event lines are pulses and are never stalled.
interface alarm_status_encoder_if;
    logic       arm_req;
    logic       code_ok;
    logic       code_bad;
    logic       sensor_trip;
    logic [2:0] color_out;
    logic       alarm_active;
    logic [1:0] fail_count;

    // Keypad/sensor front-end side: drives events, observes status.
    modport master (
        output arm_req,
        output code_ok,
        output code_bad,
        output sensor_trip,
        input  color_out,
        input  alarm_active,
        input  fail_count
    );

    // Encoder side: consumes events, drives status.
    modport slave (
        input  arm_req,
        input  code_ok,
        input  code_bad,
        input  sensor_trip,
        output color_out,
        output alarm_active,
        output fail_count
    );
endinterface

// File: rtl/alarm_status_encoder.sv
// Alarm-system state machine producing the RGB LED driver colour command.
// Latency: inputs sampled at a rising edge; state and all outputs update on that same edge.
// Backpressure: none; every input pulse is consumed (or deliberately ignored) in its cycle.
module alarm_status_encoder #(
    parameter int TICK_DIV       = 50000000,
    parameter int SELFTEST_TICKS = 2,
    parameter int ARM_TICKS      = 10,
    parameter int ENTRY_TICKS    = 15,
    parameter int GREEN_TICKS    = 3,
    parameter int MAX_FAILS      = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    alarm_status_encoder_if.slave  bus
);

    // Prescaler width; a divide-by-one still needs one (constant zero) bit.
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    // A timed state ends on the tick where the tick counter still holds N-1,
    // which lands exactly N*TICK_DIV cycles after the entry edge.
    localparam logic [7:0] SELFTEST_LAST = 8'(SELFTEST_TICKS - 1);
    localparam logic [7:0] ARM_LAST      = 8'(ARM_TICKS - 1);
    localparam logic [7:0] ENTRY_LAST    = 8'(ENTRY_TICKS - 1);
    localparam logic [7:0] GREEN_LAST    = 8'(GREEN_TICKS - 1);
    localparam logic [7:0] FAIL_LIMIT    = 8'(MAX_FAILS);

    // LED driver colour map.
    localparam logic [2:0] COL_IDLE     = 3'b000;
    localparam logic [2:0] COL_SELFTEST = 3'b001;
    localparam logic [2:0] COL_ARMING   = 3'b010;
    localparam logic [2:0] COL_ARMED    = 3'b011;
    localparam logic [2:0] COL_ALARM    = 3'b100;
    localparam logic [2:0] COL_ENTRY    = 3'b101;
    localparam logic [2:0] COL_DISARMED = 3'b110;

    // Encoding 3'd7 is unused and recovers to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELFTEST = 3'd1,
        ST_ARMING   = 3'd2,
        ST_ARMED    = 3'd3,
        ST_ALARM    = 3'd4,
        ST_ENTRY    = 3'd5,
        ST_DISARMED = 3'd6
    } state_t;

    logic arm_req;
    logic code_ok;
    logic code_bad;
    logic sensor_trip;

    assign arm_req     = bus.arm_req;
    assign code_ok     = bus.code_ok;
    assign code_bad    = bus.code_bad;
    assign sensor_trip = bus.sensor_trip;

    state_t            state_q;
    state_t            state_d;
    logic [PRE_W-1:0]  pre_q;
    logic [7:0]        tick_cnt_q;
    logic              tick;
    logic              timed;
    logic [7:0]        tick_last;
    logic              timeout;
    logic [1:0]        fail_q;
    logic [1:0]        fail_d;
    logic [2:0]        fail_inc;
    logic [1:0]        fail_sat;
    logic [2:0]        color_q;
    logic [2:0]        color_d;
    logic              alarm_q;

    assign tick = (pre_q == PRE_LAST);

    // Wrong-code count after one more code_bad, saturating in the 2-bit output.
    assign fail_inc = {1'b0, fail_q} + 3'd1;
    assign fail_sat = fail_inc[2] ? 2'd3 : fail_inc[1:0];

    // Select the tick budget of the current state; untimed states never time out.
    always_comb begin
        timed     = 1'b0;
        tick_last = 8'hFF;
        case (state_q)
            ST_SELFTEST: begin
                timed     = 1'b1;
                tick_last = SELFTEST_LAST;
            end
            ST_ARMING: begin
                timed     = 1'b1;
                tick_last = ARM_LAST;
            end
            ST_ENTRY: begin
                timed     = 1'b1;
                tick_last = ENTRY_LAST;
            end
            ST_DISARMED: begin
                timed     = 1'b1;
                tick_last = GREEN_LAST;
            end
            default: ;
        endcase
    end

    assign timeout = timed && tick && (tick_cnt_q == tick_last);

    // Next state and next wrong-code count; priority is code_ok > code_bad > sensor_trip > timeout.
    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        case (state_q)
            ST_SELFTEST: begin
                if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (arm_req) begin
                    state_d = ST_ARMING;
                end
            end
            ST_ARMING: begin
                if (code_ok) begin
                    state_d = ST_IDLE;
                end else if (timeout) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (code_ok) begin
                    state_d = ST_DISARMED;
                    fail_d  = 2'd0;
                end else if (sensor_trip) begin
                    state_d = ST_ENTRY;
                    fail_d  = 2'd0;
                end
            end
            ST_ENTRY: begin
                if (code_ok) begin
                    // A coincident code_bad is dropped: the right code wins.
                    state_d = ST_DISARMED;
                    fail_d  = 2'd0;
                end else if (code_bad) begin
                    fail_d = fail_sat;
                    if ({5'd0, fail_inc} == FAIL_LIMIT || timeout) begin
                        state_d = ST_ALARM;
                    end
                end else if (timeout) begin
                    state_d = ST_ALARM;
                end
            end
            ST_ALARM: begin
                if (code_ok) begin
                    state_d = ST_DISARMED;
                    fail_d  = 2'd0;
                end
            end
            ST_DISARMED: begin
                if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                fail_d  = 2'd0;
            end
        endcase
    end

    // Colour is decoded from the next state so it lands on the same edge as the state.
    always_comb begin
        color_d = COL_IDLE;
        case (state_d)
            ST_SELFTEST: color_d = COL_SELFTEST;
            ST_IDLE:     color_d = COL_IDLE;
            ST_ARMING:   color_d = COL_ARMING;
            ST_ARMED:    color_d = COL_ARMED;
            ST_ENTRY:    color_d = COL_ENTRY;
            ST_ALARM:    color_d = COL_ALARM;
            ST_DISARMED: color_d = COL_DISARMED;
            default:     color_d = COL_IDLE;
        endcase
    end

    // State register; reset always restarts the self-test.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SELFTEST;
        end else begin
            state_q <= state_d;
        end
    end

    // Prescaler and tick counter restart on every state change so each timed state runs from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q      <= '0;
            tick_cnt_q <= '0;
        end else if (state_d != state_q) begin
            pre_q      <= '0;
            tick_cnt_q <= '0;
        end else if (tick) begin
            pre_q      <= '0;
            tick_cnt_q <= tick_cnt_q + 8'd1;
        end else begin
            pre_q      <= pre_q + PRE_W'(1);
        end
    end

    // Registered outputs, all updated on the edge that moves the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            color_q <= COL_SELFTEST;
            alarm_q <= 1'b0;
            fail_q  <= 2'd0;
        end else begin
            color_q <= color_d;
            alarm_q <= (state_d == ST_ALARM);
            fail_q  <= fail_d;
        end
    end

    assign bus.color_out    = color_q;
    assign bus.alarm_active = alarm_q;
    assign bus.fail_count   = fail_q;

endmodule

// File: tb/tb_alarm_status_encoder.sv
// Testbench for alarm_status_encoder with a small tick divider.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is one record per clock.
module tb_alarm_status_encoder;

    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] ARM  = 4'b1000;
    localparam logic [3:0] OK   = 4'b0100;
    localparam logic [3:0] BAD  = 4'b0010;
    localparam logic [3:0] TRIP = 4'b0001;

    typedef struct packed {
        logic [2:0] color;
        logic       alarm;
        logic [1:0] fail;
    } exp_t;

    typedef struct {
        logic [3:0] ins;
        int         cycles;
        exp_t       exp;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t sb_q[$];
    rec_t tbl[$];

    alarm_status_encoder_if bus();

    alarm_status_encoder #(
        .TICK_DIV       (4),
        .SELFTEST_TICKS (2),
        .ARM_TICKS      (3),
        .ENTRY_TICKS    (5),
        .GREEN_TICKS    (2),
        .MAX_FAILS      (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic [3:0] ins, input int n,
                                input logic [2:0] col, input logic al, input logic [1:0] fl);
        rec_t r;
        r.ins       = ins;
        r.cycles    = n;
        r.exp.color = col;
        r.exp.alarm = al;
        r.exp.fail  = fl;
        tbl.push_back(r);
    endfunction

    task automatic compare(input string lbl);
        exp_t e;
        exp_t a;
        e = sb_q.pop_front();
        a = {bus.color_out, bus.alarm_active, bus.fail_count};
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got color=%b alarm=%b fail=%0d, want color=%b alarm=%b fail=%0d",
                     lbl, a.color, a.alarm, a.fail, e.color, e.alarm, e.fail);
        end
    endtask

    // Expected outputs right now, without a clock edge (async reset checks).
    task automatic check_now(input string lbl, input logic [2:0] col, input logic al, input logic [1:0] fl);
        sb_q.push_back({col, al, fl});
        compare(lbl);
    endtask

    // One clock: drive inputs, queue the expectation, sample after the edge.
    task automatic cyc(input string lbl, input logic [3:0] ins,
                       input logic [2:0] col, input logic al, input logic [1:0] fl);
        bus.arm_req     = ins[3];
        bus.code_ok     = ins[2];
        bus.code_bad    = ins[1];
        bus.sensor_trip = ins[0];
        sb_q.push_back({col, al, fl});
        @(posedge clk);
        #1;
        bus.arm_req     = 1'b0;
        bus.code_ok     = 1'b0;
        bus.code_bad    = 1'b0;
        bus.sensor_trip = 1'b0;
        compare(lbl);
    endtask

    task automatic idle_n(input string lbl, input int n,
                          input logic [2:0] col, input logic al, input logic [1:0] fl);
        for (int k = 0; k < n; k++) begin
            cyc($sformatf("%s.%0d", lbl, k), NONE, col, al, fl);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.arm_req     = 1'b0;
        bus.code_ok     = 1'b0;
        bus.code_bad    = 1'b0;
        bus.sensor_trip = 1'b0;

        // SELFTEST for 8 cycles, then IDLE stays put.
        add(NONE, 7, 3'b001, 1'b0, 2'd0);
        add(NONE, 6, 3'b000, 1'b0, 2'd0);
        // Arm; arm_req, sensor_trip and code_bad are ignored during the 12-cycle exit delay.
        add(ARM,  1, 3'b010, 1'b0, 2'd0);
        add(NONE, 2, 3'b010, 1'b0, 2'd0);
        add(ARM,  1, 3'b010, 1'b0, 2'd0);
        add(NONE, 1, 3'b010, 1'b0, 2'd0);
        add(TRIP, 1, 3'b010, 1'b0, 2'd0);
        add(BAD,  1, 3'b010, 1'b0, 2'd0);
        add(NONE, 5, 3'b010, 1'b0, 2'd0);
        add(NONE, 1, 3'b011, 1'b0, 2'd0);
        add(ARM,  1, 3'b011, 1'b0, 2'd0);
        add(NONE, 2, 3'b011, 1'b0, 2'd0);
        // Entry delay expires into ALARM; trip/bad ignored there; code_ok disarms.
        add(TRIP, 1, 3'b101, 1'b0, 2'd0);
        add(NONE, 19, 3'b101, 1'b0, 2'd0);
        add(NONE, 1, 3'b100, 1'b1, 2'd0);
        add(TRIP, 1, 3'b100, 1'b1, 2'd0);
        add(BAD,  1, 3'b100, 1'b1, 2'd0);
        add(NONE, 2, 3'b100, 1'b1, 2'd0);
        add(OK,   1, 3'b110, 1'b0, 2'd0);
        add(NONE, 7, 3'b110, 1'b0, 2'd0);
        add(NONE, 3, 3'b000, 1'b0, 2'd0);
        // Three wrong codes two cycles apart force ALARM; count then holds.
        add(ARM,  1, 3'b010, 1'b0, 2'd0);
        add(NONE, 11, 3'b010, 1'b0, 2'd0);
        add(NONE, 1, 3'b011, 1'b0, 2'd0);
        add(TRIP, 1, 3'b101, 1'b0, 2'd0);
        add(BAD,  1, 3'b101, 1'b0, 2'd1);
        add(NONE, 1, 3'b101, 1'b0, 2'd1);
        add(BAD,  1, 3'b101, 1'b0, 2'd2);
        add(NONE, 1, 3'b101, 1'b0, 2'd2);
        add(BAD,  1, 3'b100, 1'b1, 2'd3);
        add(BAD,  1, 3'b100, 1'b1, 2'd3);
        add(OK,   1, 3'b110, 1'b0, 2'd0);
        add(NONE, 7, 3'b110, 1'b0, 2'd0);
        add(NONE, 1, 3'b000, 1'b0, 2'd0);
        // code_ok with code_bad: bad is discarded, DISARMED clears the count.
        add(ARM,  1, 3'b010, 1'b0, 2'd0);
        add(NONE, 11, 3'b010, 1'b0, 2'd0);
        add(NONE, 1, 3'b011, 1'b0, 2'd0);
        add(TRIP, 1, 3'b101, 1'b0, 2'd0);
        add(BAD,  1, 3'b101, 1'b0, 2'd1);
        add(OK | BAD, 1, 3'b110, 1'b0, 2'd0);
        add(NONE, 7, 3'b110, 1'b0, 2'd0);
        add(NONE, 1, 3'b000, 1'b0, 2'd0);
        // Cancel at cycle 5 of ARMING; later code_ok (with trip) in ARMED disarms directly.
        add(ARM,  1, 3'b010, 1'b0, 2'd0);
        add(NONE, 4, 3'b010, 1'b0, 2'd0);
        add(OK,   1, 3'b000, 1'b0, 2'd0);
        add(NONE, 2, 3'b000, 1'b0, 2'd0);
        add(ARM,  1, 3'b010, 1'b0, 2'd0);
        add(NONE, 11, 3'b010, 1'b0, 2'd0);
        add(NONE, 1, 3'b011, 1'b0, 2'd0);
        add(OK | TRIP, 1, 3'b110, 1'b0, 2'd0);
        add(NONE, 7, 3'b110, 1'b0, 2'd0);
        add(NONE, 1, 3'b000, 1'b0, 2'd0);
        // code_ok on the entry-timeout edge wins.
        add(ARM,  1, 3'b010, 1'b0, 2'd0);
        add(NONE, 11, 3'b010, 1'b0, 2'd0);
        add(NONE, 1, 3'b011, 1'b0, 2'd0);
        add(TRIP, 1, 3'b101, 1'b0, 2'd0);
        add(NONE, 19, 3'b101, 1'b0, 2'd0);
        add(OK,   1, 3'b110, 1'b0, 2'd0);
        add(NONE, 7, 3'b110, 1'b0, 2'd0);
        add(NONE, 1, 3'b000, 1'b0, 2'd0);
        // code_bad on the entry-timeout edge: counted, and the timeout still alarms.
        add(ARM,  1, 3'b010, 1'b0, 2'd0);
        add(NONE, 11, 3'b010, 1'b0, 2'd0);
        add(NONE, 1, 3'b011, 1'b0, 2'd0);
        add(TRIP, 1, 3'b101, 1'b0, 2'd0);
        add(NONE, 19, 3'b101, 1'b0, 2'd0);
        add(BAD,  1, 3'b100, 1'b1, 2'd1);
        add(OK,   1, 3'b110, 1'b0, 2'd0);
        add(NONE, 7, 3'b110, 1'b0, 2'd0);
        add(NONE, 1, 3'b000, 1'b0, 2'd0);

        // Reset state, held across edges.
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_state", 3'b001, 1'b0, 2'd0);
        #2;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            for (int c = 0; c < tbl[i].cycles; c++) begin
                cyc($sformatf("vec%0d.%0d", i, c), (c == 0) ? tbl[i].ins : NONE,
                    tbl[i].exp.color, tbl[i].exp.alarm, tbl[i].exp.fail);
            end
        end

        // Asynchronous reset from ALARM between edges, then a full self-test.
        cyc("ar_arm", ARM, 3'b010, 1'b0, 2'd0);
        idle_n("ar_arming", 11, 3'b010, 1'b0, 2'd0);
        cyc("ar_armed", NONE, 3'b011, 1'b0, 2'd0);
        cyc("ar_trip", TRIP, 3'b101, 1'b0, 2'd0);
        cyc("ar_bad1", BAD, 3'b101, 1'b0, 2'd1);
        cyc("ar_bad2", BAD, 3'b101, 1'b0, 2'd2);
        cyc("ar_bad3", BAD, 3'b100, 1'b1, 2'd3);
        idle_n("ar_alarm", 2, 3'b100, 1'b1, 2'd3);
        #2;
        rst = 1'b1;
        #1;
        check_now("ar_async", 3'b001, 1'b0, 2'd0);
        cyc("ar_held", NONE, 3'b001, 1'b0, 2'd0);
        #2;
        rst = 1'b0;
        idle_n("ar_selftest", 7, 3'b001, 1'b0, 2'd0);
        cyc("ar_idle", NONE, 3'b000, 1'b0, 2'd0);

        // Reset with the ARMING timer part-way counted; nothing of it survives.
        cyc("pr_arm", ARM, 3'b010, 1'b0, 2'd0);
        idle_n("pr_arming", 5, 3'b010, 1'b0, 2'd0);
        #2;
        rst = 1'b1;
        #1;
        check_now("pr_async", 3'b001, 1'b0, 2'd0);
        #1;
        rst = 1'b0;
        idle_n("pr_selftest", 7, 3'b001, 1'b0, 2'd0);
        cyc("pr_idle", NONE, 3'b000, 1'b0, 2'd0);
        cyc("pr_rearm", ARM, 3'b010, 1'b0, 2'd0);
        idle_n("pr_arming2", 11, 3'b010, 1'b0, 2'd0);
        cyc("pr_armed", NONE, 3'b011, 1'b0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
